dmac_wr_arbiter: RTL and testbench

//  Sits downstream of the N DMA channel engines and upstream of the shared AXI write port of the DMAC top.

---
 rtl/dmac_wr_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_dmac_wr_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_wr_arbiter.sv
// DMAC shared AXI write-port arbiter.
// Grants channel AW requests round-robin and issues one AW per grant. The grant order is
// recorded so W bursts follow the same order. B responses are routed back to channels by bid.
module dmac_wr_arbiter #(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned ORD_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // Channel-side AW
   input  logic [N_CH-1:0]            ch_awvalid_i,
   input  logic [N_CH*ADDR_W-1:0]     ch_awaddr_i,
   input  logic [N_CH*4-1:0]          ch_awlen_i,
   output logic [N_CH-1:0]            ch_awready_o,
   // Channel-side W
   input  logic [N_CH*DATA_W-1:0]     ch_wdata_i,
   input  logic [N_CH*DATA_W/8-1:0]   ch_wstrb_i,
   input  logic [N_CH-1:0]            ch_wlast_i,
   input  logic [N_CH-1:0]            ch_wvalid_i,
   output logic [N_CH-1:0]            ch_wready_o,
   // Channel-side B
   output logic [N_CH-1:0]            ch_bvalid_o,
   output logic [N_CH*2-1:0]          ch_bresp_o,
   input  logic [N_CH-1:0]            ch_bready_i,
   // AXI AW
   output logic [ID_W-1:0]            awid_o,
   output logic [ADDR_W-1:0]          awaddr_o,
   output logic [3:0]                 awlen_o,
   output logic [2:0]                 awsize_o,
   output logic [1:0]                 awburst_o,
   output logic                       awvalid_o,
   input  logic                       awready_i,
   // AXI W
   output logic [ID_W-1:0]            wid_o,
   output logic [DATA_W-1:0]          wdata_o,
   output logic [DATA_W/8-1:0]        wstrb_o,
   output logic                       wlast_o,
   output logic                       wvalid_o,
   input  logic                       wready_i,
   // AXI B
   input  logic [ID_W-1:0]            bid_i,
   input  logic [1:0]                 bresp_i,
   input  logic                       bvalid_i,
   output logic                       bready_o
);

   localparam int unsigned CH_W   = $clog2(N_CH);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned PTR_W  = $clog2(ORD_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic [2:0]  AwSize      = 3'($clog2(STRB_W));
   localparam logic [1:0]  AwBurstIncr = 2'b01;

   typedef enum logic [0:0] {StIdle, StIssue} aw_state_e;

   aw_state_e         aw_state_q, aw_state_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]   awid_q, awid_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [3:0]        awlen_q, awlen_d;

   // Grant-order FIFO: each entry is the channel whose W burst goes next
   logic [CH_W-1:0]   ord_mem_q [ORD_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fifo_full, fifo_empty;
   logic              push, pop;
   logic [CH_W-1:0]   head;

   logic              win_found;
   logic [CH_W-1:0]   win_idx;
   logic              grant;
   logic [CH_W-1:0]   bid_sel;

   assign fifo_full  = (cnt_q == CNT_W'(ORD_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign head       = ord_mem_q[rd_ptr_q];
   assign grant      = (aw_state_q == StIdle) && win_found && !fifo_full;
   assign push       = grant;
   assign pop        = !fifo_empty && ch_wvalid_i[head] && wready_i && ch_wlast_i[head];
   assign bid_sel    = bid_i[CH_W-1:0];

   // Round-robin search: first requester at or after the pointer, wrapping
   always_comb begin
      int unsigned k;
      win_found = 1'b0;
      win_idx   = '0;
      k         = 0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         k = (int'(rr_ptr_q) + i) % N_CH;
         if (!win_found && ch_awvalid_i[k[CH_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = k[CH_W-1:0];
         end
      end
   end

   // One-cycle accept pulse to the winning channel
   always_comb begin
      ch_awready_o = '0;
      if (grant) begin
         ch_awready_o[win_idx] = 1'b1;
      end
   end

   // AW FSM next state: latch the winner in IDLE, hold fields stable in ISSUE
   always_comb begin
      aw_state_d = aw_state_q;
      rr_ptr_d   = rr_ptr_q;
      awid_d     = awid_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      unique case (aw_state_q)
         StIdle: begin
            if (grant) begin
               awid_d     = win_idx;
               awaddr_d   = ch_awaddr_i[win_idx*ADDR_W +: ADDR_W];
               awlen_d    = ch_awlen_i[win_idx*4 +: 4];
               rr_ptr_d   = (win_idx == CH_W'(N_CH - 1)) ? '0 : win_idx + CH_W'(1);
               aw_state_d = StIssue;
            end
         end
         StIssue: begin
            if (awready_i) begin
               aw_state_d = StIdle;
            end
         end
         default: aw_state_d = StIdle;
      endcase
   end

   // AW state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_state_q <= StIdle;
         rr_ptr_q   <= '0;
         awid_q     <= '0;
         awaddr_q   <= '0;
         awlen_q    <= '0;
      end else begin
         aw_state_q <= aw_state_d;
         rr_ptr_q   <= rr_ptr_d;
         awid_q     <= awid_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
      end
   end

   // Order FIFO pointer/count next state; push and pop may coincide
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Order FIFO storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < ORD_DEPTH; i++) begin
            ord_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push) begin
            ord_mem_q[wr_ptr_q] <= win_idx;
         end
      end
   end

   // AXI AW outputs come straight from the latched grant
   always_comb begin
      awvalid_o = (aw_state_q == StIssue);
      awid_o    = ID_W'(awid_q);
      awaddr_o  = awaddr_q;
      awlen_o   = awlen_q;
      awsize_o  = awvalid_o ? AwSize : 3'b000;
      awburst_o = awvalid_o ? AwBurstIncr : 2'b00;
   end

   // W steering: only the FIFO head channel sees the shared port
   always_comb begin
      wvalid_o    = 1'b0;
      wid_o       = '0;
      wdata_o     = '0;
      wstrb_o     = '0;
      wlast_o     = 1'b0;
      ch_wready_o = '0;
      if (!fifo_empty) begin
         wvalid_o          = ch_wvalid_i[head];
         wid_o             = ID_W'(head);
         wdata_o           = ch_wdata_i[head*DATA_W +: DATA_W];
         wstrb_o           = ch_wstrb_i[head*STRB_W +: STRB_W];
         wlast_o           = ch_wlast_i[head];
         ch_wready_o[head] = wready_i;
      end
   end

   // B routing by bid; unknown ids are accepted and dropped
   always_comb begin
      ch_bvalid_o = '0;
      ch_bresp_o  = '0;
      bready_o    = 1'b1;
      if (bid_i < ID_W'(N_CH)) begin
         ch_bvalid_o[bid_sel]        = bvalid_i;
         ch_bresp_o[bid_sel*2 +: 2]  = bresp_i;
         bready_o                    = ch_bready_i[bid_sel];
      end
   end

endmodule

// File: tb/tb_dmac_wr_arbiter.sv
// Randomized bench for dmac_wr_arbiter against a queue-based reference model.
module tb_dmac_wr_arbiter;

   localparam int unsigned N_CH      = 4;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ID_W      = 4;
   localparam int unsigned ORD_DEPTH = 4;
   localparam int unsigned STRB_W    = DATA_W / 8;
   localparam int unsigned CH_W      = 2;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [N_CH-1:0]          ch_awvalid_i;
   logic [N_CH*ADDR_W-1:0]   ch_awaddr_i;
   logic [N_CH*4-1:0]        ch_awlen_i;
   logic [N_CH-1:0]          ch_awready_o;
   logic [N_CH*DATA_W-1:0]   ch_wdata_i;
   logic [N_CH*STRB_W-1:0]   ch_wstrb_i;
   logic [N_CH-1:0]          ch_wlast_i;
   logic [N_CH-1:0]          ch_wvalid_i;
   logic [N_CH-1:0]          ch_wready_o;
   logic [N_CH-1:0]          ch_bvalid_o;
   logic [N_CH*2-1:0]        ch_bresp_o;
   logic [N_CH-1:0]          ch_bready_i;
   logic [ID_W-1:0]          awid_o;
   logic [ADDR_W-1:0]        awaddr_o;
   logic [3:0]               awlen_o;
   logic [2:0]               awsize_o;
   logic [1:0]               awburst_o;
   logic                     awvalid_o;
   logic                     awready_i;
   logic [ID_W-1:0]          wid_o;
   logic [DATA_W-1:0]        wdata_o;
   logic [STRB_W-1:0]        wstrb_o;
   logic                     wlast_o;
   logic                     wvalid_o;
   logic                     wready_i;
   logic [ID_W-1:0]          bid_i;
   logic [1:0]               bresp_i;
   logic                     bvalid_i;
   logic                     bready_o;

   dmac_wr_arbiter #(
      .N_CH      (N_CH),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .ID_W      (ID_W),
      .ORD_DEPTH (ORD_DEPTH)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_awvalid_i (ch_awvalid_i),
      .ch_awaddr_i  (ch_awaddr_i),
      .ch_awlen_i   (ch_awlen_i),
      .ch_awready_o (ch_awready_o),
      .ch_wdata_i   (ch_wdata_i),
      .ch_wstrb_i   (ch_wstrb_i),
      .ch_wlast_i   (ch_wlast_i),
      .ch_wvalid_i  (ch_wvalid_i),
      .ch_wready_o  (ch_wready_o),
      .ch_bvalid_o  (ch_bvalid_o),
      .ch_bresp_o   (ch_bresp_o),
      .ch_bready_i  (ch_bready_i),
      .awid_o       (awid_o),
      .awaddr_o     (awaddr_o),
      .awlen_o      (awlen_o),
      .awsize_o     (awsize_o),
      .awburst_o    (awburst_o),
      .awvalid_o    (awvalid_o),
      .awready_i    (awready_i),
      .wid_o        (wid_o),
      .wdata_o      (wdata_o),
      .wstrb_o      (wstrb_o),
      .wlast_o      (wlast_o),
      .wvalid_o     (wvalid_o),
      .wready_i     (wready_i),
      .bid_i        (bid_i),
      .bresp_i      (bresp_i),
      .bvalid_i     (bvalid_i),
      .bready_o     (bready_o)
   );

   always #5 clk = ~clk;

   // Reference model: one pending AW at most, plus the list of granted channels awaiting W
   typedef struct packed {
      logic [CH_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        len;
   } aw_t;

   aw_t aw_q[$];
   int  ord_q[$];
   int  m_ptr;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      aw_q.delete();
      ord_q.delete();
      m_ptr = 0;
   endtask

   task automatic drive_quiet();
      ch_awvalid_i = '0;
      ch_awaddr_i  = '0;
      ch_awlen_i   = '0;
      ch_wdata_i   = '0;
      ch_wstrb_i   = '0;
      ch_wlast_i   = '0;
      ch_wvalid_i  = '0;
      ch_bready_i  = '0;
      awready_i    = 1'b0;
      wready_i     = 1'b0;
      bid_i        = '0;
      bresp_i      = '0;
      bvalid_i     = 1'b0;
   endtask

   task automatic drive_random(input int unsigned wready_pct, input bit all_req);
      ch_awvalid_i = all_req ? {N_CH{1'b1}} : N_CH'($urandom);
      ch_wvalid_i  = N_CH'($urandom) | N_CH'($urandom);
      ch_wlast_i   = N_CH'($urandom) & N_CH'($urandom);
      ch_bready_i  = N_CH'($urandom);
      for (int k = 0; k < N_CH; k++) begin
         ch_awaddr_i[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
         ch_awlen_i[k*4 +: 4]            = 4'($urandom);
         ch_wdata_i[k*DATA_W +: DATA_W]  = DATA_W'($urandom);
         ch_wstrb_i[k*STRB_W +: STRB_W]  = STRB_W'($urandom);
      end
      awready_i = ($urandom_range(99) < 50);
      wready_i  = ($urandom_range(99) < wready_pct);
      bvalid_i  = 1'($urandom);
      bid_i     = ($urandom_range(99) < 70) ? ID_W'($urandom_range(N_CH - 1)) : ID_W'($urandom);
      bresp_i   = 2'($urandom);
   endtask

   // One clock: drive at the falling edge, check 1 ns later, then advance the model
   task automatic step_cycle(input int unsigned wready_pct, input bit all_req);
      int              win;
      bit              do_pop;
      aw_t             a;
      logic [CH_W-1:0] c;
      logic [CH_W-1:0] h;
      logic [CH_W-1:0] b;
      logic [N_CH-1:0] e_awready;
      logic [N_CH-1:0] e_wready;
      logic [N_CH-1:0] e_bvalid;

      @(negedge clk);
      drive_random(wready_pct, all_req);
      #1;

      // AW: a grant needs no pending AW, room for the order entry, and a requester
      win = -1;
      if (aw_q.size() == 0 && ord_q.size() < ORD_DEPTH) begin
         for (int i = 0; i < N_CH; i++) begin
            c = CH_W'((m_ptr + i) % N_CH);
            if (win < 0 && ch_awvalid_i[c]) win = int'(c);
         end
      end
      e_awready = '0;
      if (win >= 0) e_awready[CH_W'(win)] = 1'b1;
      check("ch_awready", 64'(ch_awready_o), 64'(e_awready));
      check("awvalid", 64'(awvalid_o), 64'(aw_q.size() != 0));
      if (aw_q.size() != 0) begin
         check("awid", 64'(awid_o), 64'(aw_q[0].id));
         check("awaddr", 64'(awaddr_o), 64'(aw_q[0].addr));
         check("awlen", 64'(awlen_o), 64'(aw_q[0].len));
         check("awsize", 64'(awsize_o), 64'd2);
         check("awburst", 64'(awburst_o), 64'd1);
      end

      // W: only the oldest granted channel is connected
      do_pop   = 1'b0;
      e_wready = '0;
      if (ord_q.size() != 0) begin
         h = CH_W'(ord_q[0]);
         e_wready[h] = wready_i;
         check("wvalid", 64'(wvalid_o), 64'(ch_wvalid_i[h]));
         check("wid", 64'(wid_o), 64'(h));
         check("wdata", 64'(wdata_o), 64'(ch_wdata_i[h*DATA_W +: DATA_W]));
         check("wstrb", 64'(wstrb_o), 64'(ch_wstrb_i[h*STRB_W +: STRB_W]));
         check("wlast", 64'(wlast_o), 64'(ch_wlast_i[h]));
         do_pop = ch_wvalid_i[h] && wready_i && ch_wlast_i[h];
      end else begin
         check("wvalid_empty", 64'(wvalid_o), 64'd0);
      end
      check("ch_wready", 64'(ch_wready_o), 64'(e_wready));

      // B: route by id, swallow unknown ids
      e_bvalid = '0;
      if (int'(bid_i) < N_CH) begin
         b = CH_W'(bid_i);
         e_bvalid[b] = bvalid_i;
         check("bready", 64'(bready_o), 64'(ch_bready_i[b]));
         check("ch_bresp", 64'(ch_bresp_o[b*2 +: 2]), 64'(bresp_i));
      end else begin
         check("bready_drop", 64'(bready_o), 64'd1);
      end
      check("ch_bvalid", 64'(ch_bvalid_o), 64'(e_bvalid));

      // Clock-edge effects
      if (aw_q.size() != 0 && awready_i) void'(aw_q.pop_front());
      if (do_pop) void'(ord_q.pop_front());
      if (win >= 0) begin
         c      = CH_W'(win);
         a.id   = c;
         a.addr = ch_awaddr_i[c*ADDR_W +: ADDR_W];
         a.len  = ch_awlen_i[c*4 +: 4];
         aw_q.push_back(a);
         ord_q.push_back(win);
         m_ptr = (win + 1) % N_CH;
      end
   endtask

   // Asynchronous reset in the middle of traffic; outputs must drop immediately
   task automatic reset_mid();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_awvalid", 64'(awvalid_o), 64'd0);
      check("rst_wvalid", 64'(wvalid_o), 64'd0);
      check("rst_ch_wready", 64'(ch_wready_o), 64'd0);
      model_reset();
      drive_quiet();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      drive_quiet();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_awvalid", 64'(awvalid_o), 64'd0);
      check("reset_awaddr", 64'(awaddr_o), 64'd0);
      check("reset_awid", 64'(awid_o), 64'd0);
      check("reset_wvalid", 64'(wvalid_o), 64'd0);
      check("reset_ch_awready", 64'(ch_awready_o), 64'd0);
      check("reset_ch_wready", 64'(ch_wready_o), 64'd0);
      rst_n = 1'b1;

      // First grant out of reset goes to channel 0 when everyone asks
      step_cycle(60, 1'b1);
      for (int n = 0; n < 600; n++) step_cycle(60, 1'b0);
      // Slow W side: order FIFO fills and grants stall
      for (int n = 0; n < 600; n++) step_cycle(8, 1'b0);
      reset_mid();
      step_cycle(60, 1'b1);
      // All channels requesting: round-robin rotation
      for (int n = 0; n < 300; n++) step_cycle(50, 1'b1);
      reset_mid();
      step_cycle(60, 1'b1);
      for (int n = 0; n < 400; n++) step_cycle(($urandom_range(1) != 0) ? 90 : 10, 1'b0);
      reset_mid();
      for (int n = 0; n < 200; n++) step_cycle(70, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
